// File: rtl/fmul_iter_norm.sv
// Iterative half-precision significand multiplier with normalisation and RNE rounding.
// Takes one aligned operand bundle at a time. The product is built by shift-and-add
// over 11 cycles, normalised one bit per cycle, then rounded and packed into an
// IEEE half. The result is held until the consumer accepts it.
module fmul_iter_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] frac_a,
  input  logic [10:0] frac_b,
  input  logic [6:0]  exp_sum,
  input  logic        sign,
  input  logic        s_is_nan,
  input  logic        s_is_inf,
  input  logic [9:0]  inf_nan_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_ROUND, S_HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [10:0]        r_fa;
  logic [10:0]        r_fb;
  logic               r_sign;
  logic               r_nan;
  logic               r_inf;
  logic [9:0]         r_nan_frac;
  logic signed [7:0]  r_exp;
  logic [21:0]        r_p;
  logic [3:0]         r_cnt;
  logic [15:0]        r_result;
  logic               w_accept;
  logic               w_norm_done;

  // Round the normalised product to nearest-even and pack it, with special cases first.
  function automatic logic [15:0] round_pack(
    input logic              s,
    input logic              nan,
    input logic              inf,
    input logic [9:0]        nfrac,
    input logic [21:0]       p,
    input logic signed [7:0] e_in
  );
    logic [9:0]        mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [10:0]       m_sum;
    logic signed [8:0] e;
    logic [15:0]       res;
    e = {e_in[7], e_in};
    if (p[21]) begin
      mant   = p[20:11];
      guard  = p[10];
      sticky = |p[9:0];
      e      = e + 9'sd1;
    end else begin
      mant   = p[19:10];
      guard  = p[9];
      sticky = |p[8:0];
    end
    inc   = guard & (sticky | mant[0]);
    m_sum = {1'b0, mant} + {10'b0, inc};
    // A carry out of the mantissa means it rolled over to 1.0 of the next binade.
    if (m_sum[10]) e = e + 9'sd1;
    mant = m_sum[9:0];
    if (nan)                   res = {s, 5'h1F, nfrac};
    else if (inf && p == '0)   res = {1'b0, 5'h1F, 10'h200};
    else if (inf)              res = {s, 5'h1F, 10'h000};
    else if (p == '0)          res = {s, 15'h0};
    else if (e >= 9'sd31)      res = {s, 5'h1F, 10'h000};
    else if (e <= 9'sd0)       res = {s, 15'h0};
    else                       res = {s, e[4:0], mant};
    return res;
  endfunction

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_HOLD);
  assign result      = r_result;
  assign w_accept    = in_valid && in_ready;
  assign w_norm_done = r_p[21] | r_p[20] | (r_p == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == 4'd10) w_state_nxt = S_NORM;
      S_NORM:  if (w_norm_done) w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, shift-and-add, normalisation shifts and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fa       <= frac_a;
            r_fb       <= frac_b;
            r_sign     <= sign;
            r_nan      <= s_is_nan;
            r_inf      <= s_is_inf;
            r_nan_frac <= inf_nan_frac;
            r_exp      <= {exp_sum[6], exp_sum};
            r_p        <= '0;
            r_cnt      <= '0;
          end
        end
        S_MUL: begin
          if (r_fb[r_cnt]) r_p <= r_p + ({11'b0, r_fa} << r_cnt);
          r_cnt <= r_cnt + 4'd1;
        end
        S_NORM: begin
          if (!w_norm_done) begin
            r_p   <= r_p << 1;
            r_exp <= r_exp - 8'sd1;
          end
        end
        S_ROUND: begin
          r_result <= round_pack(r_sign, r_nan, r_inf, r_nan_frac, r_p, r_exp);
        end
        default: ;
      endcase
    end
  end

endmodule
